tcp_vlg_tx_sched: RTL and testbench

Parametrised TX scheduler for a TCP connection. It multiplexes N_SRC packet requesters (payload, keep-alive, forced ACK, and later additions) onto the single TX interface using fixed-priority or round-robin arbitration. It adds a per-packet done timeout and stamps each packet with an IP packet ID. When the connection is not established, the TCP engine owns TX through a combinational bypass.

---
 rtl/tcp_vlg_tx_sched_if.sv | 29 ++
 rtl/tcp_vlg_tx_sched.sv | 141 ++++++++++++++
 tb/tb_tcp_vlg_tx_sched.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_vlg_tx_sched_if.sv
// TX-side handshake between the scheduler (master) and the TX datapath (slave).
interface tcp_vlg_tx_sched_if #(
    parameter int unsigned META_W   = 256,
    parameter int unsigned PKT_ID_W = 16
);

    logic                tx_rdy;
    logic [META_W-1:0]   tx_meta;
    logic [PKT_ID_W-1:0] tx_pkt_id;
    logic                tx_acc;
    logic                tx_done;

    modport master (
        output tx_rdy,
        output tx_meta,
        output tx_pkt_id,
        input  tx_acc,
        input  tx_done
    );

    modport slave (
        input  tx_rdy,
        input  tx_meta,
        input  tx_pkt_id,
        output tx_acc,
        output tx_done
    );

endinterface

// File: rtl/tcp_vlg_tx_sched.sv
// TCP TX scheduler: arbitrates N_SRC packet requesters onto one TX port,
// stamps packet IDs, aborts stalled packets, and hands TX to the engine
// through a combinational bypass while the connection is down.
module tcp_vlg_tx_sched #(
    parameter int unsigned N_SRC    = 3,
    parameter int unsigned META_W   = 256,
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned PKT_ID_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      connected,
    input  logic [N_SRC-1:0]          req,
    input  logic [N_SRC*META_W-1:0]   req_meta,
    output logic [N_SRC-1:0]          sent,
    output logic [N_SRC-1:0]          fail,
    input  logic                      eng_rdy,
    input  logic [META_W-1:0]         eng_meta,
    output logic                      eng_acc,
    output logic                      eng_done,
    tcp_vlg_tx_sched_if.master        tx,
    output logic                      busy
);

    localparam int unsigned IDX_W = $clog2(N_SRC);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_SENT
    } state_t;

    state_t              state;
    logic                rdy_s;
    logic [META_W-1:0]   meta_q;
    logic [IDX_W-1:0]    gnt_q;
    logic [IDX_W-1:0]    ptr;
    logic [TMR_W-1:0]    timer;
    logic [PKT_ID_W-1:0] pkt_id;

    logic                any_req_c;
    logic [IDX_W-1:0]    grant_c;
    logic [IDX_W-1:0]    ptr_next_c;
    logic                acc_s_c;
    logic                done_s_c;
    logic                timer_hit_c;

    // Scheduler only sees TX handshakes while it owns the port.
    assign acc_s_c  = connected & tx.tx_acc;
    assign done_s_c = connected & tx.tx_done;

    // Timer is 0 in the first ACTIVE cycle; abort fires as it would reach TIMEOUT-1,
    // so fail lands exactly TIMEOUT cycles after the grant decision.
    assign timer_hit_c = (timer == TMR_W'(TIMEOUT - 2));

    // Round-robin pointer moves just past the packet that leaves ACTIVE.
    assign ptr_next_c = IDX_W'((32'(gnt_q) + 32'd1) % N_SRC);

    // Grant selection: lowest index, or first requester at/after ptr with wrap.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_c   = '0;
        any_req_c = |req;
        if (RR_MODE == 0) begin
            for (int i = N_SRC - 1; i >= 0; i--) begin
                if (req[i]) grant_c = IDX_W'(i);
            end
        end else begin
            for (int k = N_SRC - 1; k >= 0; k--) begin
                idx = (32'(ptr) + 32'(k)) % N_SRC;
                if (req[idx]) grant_c = IDX_W'(idx);
            end
        end
    end

    // Scheduler FSM with registered handshake, pulse and ID state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rdy_s  <= 1'b0;
            meta_q <= '0;
            gnt_q  <= '0;
            ptr    <= '0;
            timer  <= '0;
            pkt_id <= '0;
            sent   <= '0;
            fail   <= '0;
            busy   <= 1'b0;
        end else begin
            sent <= '0;
            fail <= '0;
            case (state)
                S_IDLE: begin
                    if (connected && any_req_c) begin
                        gnt_q  <= grant_c;
                        meta_q <= req_meta[32'(grant_c) * META_W +: META_W];
                        rdy_s  <= 1'b1;
                        timer  <= '0;
                        busy   <= 1'b1;
                        state  <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    timer <= timer + TMR_W'(1);
                    if (acc_s_c) rdy_s <= 1'b0;
                    if (done_s_c) begin
                        rdy_s        <= 1'b0;
                        sent[gnt_q]  <= 1'b1;
                        pkt_id       <= pkt_id + PKT_ID_W'(1);
                        ptr          <= ptr_next_c;
                        state        <= S_SENT;
                    end else if (!connected || timer_hit_c) begin
                        rdy_s        <= 1'b0;
                        fail[gnt_q]  <= 1'b1;
                        ptr          <= ptr_next_c;
                        state        <= S_SENT;
                    end
                end
                S_SENT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // TX ownership mux: scheduler when connected, engine bypass otherwise.
    assign tx.tx_rdy    = connected ? rdy_s  : eng_rdy;
    assign tx.tx_meta   = connected ? meta_q : eng_meta;
    assign tx.tx_pkt_id = pkt_id;
    assign eng_acc      = ~connected & tx.tx_acc;
    assign eng_done     = ~connected & tx.tx_done;

endmodule

// File: tb/tb_tcp_vlg_tx_sched.sv
// Bench for tcp_vlg_tx_sched: a fixed-priority and a round-robin instance,
// directed stimulus pushing expected offers/pulses to per-instance queues,
// negedge monitors popping and comparing them.
module tb_tcp_vlg_tx_sched;

    localparam int unsigned N  = 3;
    localparam int unsigned MW = 32;
    localparam int unsigned PW = 8;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic [31:0] cyc;
        logic        kind;   // 0 = packet offered, 1 = sent/fail pulse
        logic        rdy;
        logic [31:0] meta;
        logic [7:0]  pid;
        logic [2:0]  sent;
        logic [2:0]  fail;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    ev_t exp_f[$];
    ev_t exp_r[$];
    ev_t fo, ro;
    logic f_busy_q = 1'b0;
    logic r_busy_q = 1'b0;
    logic [7:0] f_pid, r_pid;

    logic              f_conn, r_conn;
    logic [N-1:0]      f_req, r_req, f_sent, r_sent, f_fail, r_fail;
    logic [N*MW-1:0]   f_rmeta, r_rmeta;
    logic              f_eng_rdy, r_eng_rdy, f_eng_acc, r_eng_acc, f_eng_done, r_eng_done;
    logic [MW-1:0]     f_eng_meta, r_eng_meta;
    logic              f_busy, r_busy;

    tcp_vlg_tx_sched_if #(.META_W(MW), .PKT_ID_W(PW)) f_if ();
    tcp_vlg_tx_sched_if #(.META_W(MW), .PKT_ID_W(PW)) r_if ();

    tcp_vlg_tx_sched #(.N_SRC(N), .META_W(MW), .RR_MODE(0), .TIMEOUT(TO), .PKT_ID_W(PW)) u_fp (
        .clk(clk), .rst(rst), .connected(f_conn), .req(f_req), .req_meta(f_rmeta),
        .sent(f_sent), .fail(f_fail), .eng_rdy(f_eng_rdy), .eng_meta(f_eng_meta),
        .eng_acc(f_eng_acc), .eng_done(f_eng_done), .tx(f_if), .busy(f_busy)
    );

    tcp_vlg_tx_sched #(.N_SRC(N), .META_W(MW), .RR_MODE(1), .TIMEOUT(TO), .PKT_ID_W(PW)) u_rr (
        .clk(clk), .rst(rst), .connected(r_conn), .req(r_req), .req_meta(r_rmeta),
        .sent(r_sent), .fail(r_fail), .eng_rdy(r_eng_rdy), .eng_meta(r_eng_meta),
        .eng_acc(r_eng_acc), .eng_done(r_eng_done), .tx(r_if), .busy(r_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] src_meta(input int g);
        case (g)
            0:       return 32'h0000_005A;
            1:       return 32'h0000_00A5;
            default: return 32'h0000_00C3;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit rr, input ev_t e);
        if (rr) exp_r.push_back(e);
        else    exp_f.push_back(e);
    endtask

    task automatic sb_check(input bit rr, input ev_t o);
        ev_t e;
        n_vec++;
        if ((rr && exp_r.size() == 0) || (!rr && exp_f.size() == 0)) begin
            n_err++;
            $display("FAIL sb_%s_unexpected: got cyc=%0d kind=%0d pid=%0h sent=%b fail=%b, want no event",
                     rr ? "rr" : "fp", o.cyc, o.kind, o.pid, o.sent, o.fail);
            return;
        end
        e = rr ? exp_r.pop_front() : exp_f.pop_front();
        if (o !== e) begin
            n_err++;
            $display("FAIL sb_%s: got cyc=%0d kind=%0d rdy=%b meta=%0h pid=%0h sent=%b fail=%b; want cyc=%0d kind=%0d rdy=%b meta=%0h pid=%0h sent=%b fail=%b",
                     rr ? "rr" : "fp", o.cyc, o.kind, o.rdy, o.meta, o.pid, o.sent, o.fail,
                     e.cyc, e.kind, e.rdy, e.meta, e.pid, e.sent, e.fail);
        end
    endtask

    task automatic drive_tx(input bit rr, input logic a, input logic d);
        if (rr) begin
            r_if.tx_acc  = a;
            r_if.tx_done = d;
        end else begin
            f_if.tx_acc  = a;
            f_if.tx_done = d;
        end
    endtask

    // Called in an IDLE cycle with req already set; acc one cycle after grant,
    // done done_dly cycles after grant; returns in the next IDLE cycle.
    task automatic serve(input bit rr, input int g, input int done_dly, input bit keep);
        ev_t        e;
        logic [7:0] pid;
        logic [2:0] oh;
        pid = rr ? r_pid : f_pid;
        oh  = 3'b001 << g;
        e = '{cyc: 32'(cyc + 1), kind: 1'b0, rdy: 1'b1, meta: src_meta(g), pid: pid,
              sent: 3'b000, fail: 3'b000};
        push_exp(rr, e);
        e = '{cyc: 32'(cyc + done_dly + 1), kind: 1'b1, rdy: 1'b0, meta: 32'h0, pid: pid + 8'd1,
              sent: oh, fail: 3'b000};
        push_exp(rr, e);
        for (int k = 1; k <= done_dly; k++) begin
            step(1);
            drive_tx(rr, k == 1, k == done_dly);
        end
        step(1);
        drive_tx(rr, 1'b0, 1'b0);
        if (!keep) begin
            if (rr) r_req = r_req & ~oh;
            else    f_req = f_req & ~oh;
        end
        if (rr) r_pid = pid + 8'd1;
        else    f_pid = pid + 8'd1;
        step(1);
    endtask

    // Monitors: a busy rising edge is a new offer; any sent/fail bit is a pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (f_busy && !f_busy_q) begin
                fo = '{cyc: 32'(cyc), kind: 1'b0, rdy: f_if.tx_rdy, meta: f_if.tx_meta,
                       pid: f_if.tx_pkt_id, sent: 3'b000, fail: 3'b000};
                sb_check(1'b0, fo);
            end
            if ((f_sent | f_fail) != 3'b000) begin
                fo = '{cyc: 32'(cyc), kind: 1'b1, rdy: 1'b0, meta: 32'h0,
                       pid: f_if.tx_pkt_id, sent: f_sent, fail: f_fail};
                sb_check(1'b0, fo);
            end
        end
        f_busy_q = f_busy;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (r_busy && !r_busy_q) begin
                ro = '{cyc: 32'(cyc), kind: 1'b0, rdy: r_if.tx_rdy, meta: r_if.tx_meta,
                       pid: r_if.tx_pkt_id, sent: 3'b000, fail: 3'b000};
                sb_check(1'b1, ro);
            end
            if ((r_sent | r_fail) != 3'b000) begin
                ro = '{cyc: 32'(cyc), kind: 1'b1, rdy: 1'b0, meta: 32'h0,
                       pid: r_if.tx_pkt_id, sent: r_sent, fail: r_fail};
                sb_check(1'b1, ro);
            end
        end
        r_busy_q = r_busy;
    end

    initial begin
        ev_t e;
        rst = 1'b1;
        f_conn = 1'b1; r_conn = 1'b1;
        f_req = '0; r_req = '0;
        f_rmeta = {32'h0000_00C3, 32'h0000_00A5, 32'h0000_005A};
        r_rmeta = {32'h0000_00C3, 32'h0000_00A5, 32'h0000_005A};
        f_eng_rdy = 1'b0; r_eng_rdy = 1'b0;
        f_eng_meta = '0; r_eng_meta = '0;
        drive_tx(1'b0, 1'b0, 1'b0);
        drive_tx(1'b1, 1'b0, 1'b0);
        f_pid = 8'h00; r_pid = 8'h00;

        // Reset state
        step(2);
        chk("rst_tx_rdy", 32'(f_if.tx_rdy), 32'h0);
        chk("rst_busy", 32'(f_busy), 32'h0);
        chk("rst_sent_fail", 32'({f_sent, f_fail}), 32'h0);
        chk("rst_pkt_id", 32'(f_if.tx_pkt_id), 32'h0);
        chk("rst_meta", f_if.tx_meta, 32'h0);
        chk("rst_rr_busy", 32'(r_busy), 32'h0);
        rst = 1'b0;
        step(1);

        // Single request: src 1, acc at t+2, done at t+5
        f_req = 3'b010;
        e = '{cyc: 32'(cyc + 1), kind: 1'b0, rdy: 1'b1, meta: 32'hA5, pid: 8'h00, sent: 3'b000, fail: 3'b000};
        push_exp(1'b0, e);
        e = '{cyc: 32'(cyc + 6), kind: 1'b1, rdy: 1'b0, meta: 32'h0, pid: 8'h01, sent: 3'b010, fail: 3'b000};
        push_exp(1'b0, e);
        step(2);                                     // t+2
        f_if.tx_acc = 1'b1;
        chk("t1_rdy_before_acc", 32'(f_if.tx_rdy), 32'h1);
        step(1);                                     // t+3
        f_if.tx_acc = 1'b0;
        chk("t1_rdy_after_acc", 32'(f_if.tx_rdy), 32'h0);
        chk("t1_meta", f_if.tx_meta, 32'hA5);
        step(2);                                     // t+5
        f_if.tx_done = 1'b1;
        #1;
        chk("t1_eng_done_conn", 32'(f_eng_done), 32'h0);
        step(1);                                     // t+6 SENT
        f_if.tx_done = 1'b0;
        f_req = 3'b000;
        f_pid = 8'h01;
        chk("t1_busy_in_sent", 32'(f_busy), 32'h1);
        step(1);                                     // t+7 IDLE
        chk("t1_busy_idle", 32'(f_busy), 32'h0);

        // Fixed priority: src 1 starves src 2 until it drops
        f_req = 3'b110;
        serve(1'b0, 1, 2, 1'b1);
        serve(1'b0, 1, 2, 1'b1);
        serve(1'b0, 1, 2, 1'b0);
        serve(1'b0, 2, 2, 1'b0);

        // Timeout on src 0, then src 2 granted right after
        f_req = 3'b001;
        e = '{cyc: 32'(cyc + 1), kind: 1'b0, rdy: 1'b1, meta: 32'h5A, pid: f_pid, sent: 3'b000, fail: 3'b000};
        push_exp(1'b0, e);
        e = '{cyc: 32'(cyc + TO), kind: 1'b1, rdy: 1'b0, meta: 32'h0, pid: f_pid, sent: 3'b000, fail: 3'b001};
        push_exp(1'b0, e);
        step(TO - 1);
        chk("to_rdy_held", 32'(f_if.tx_rdy), 32'h1);
        step(1);
        chk("to_rdy_dropped", 32'(f_if.tx_rdy), 32'h0);
        f_req = 3'b100;
        step(1);
        serve(1'b0, 2, 2, 1'b0);

        // Disconnect mid-packet: bypass takes over, src 1 fails
        f_req = 3'b010;
        e = '{cyc: 32'(cyc + 1), kind: 1'b0, rdy: 1'b1, meta: 32'hA5, pid: f_pid, sent: 3'b000, fail: 3'b000};
        push_exp(1'b0, e);
        e = '{cyc: 32'(cyc + 4), kind: 1'b1, rdy: 1'b0, meta: 32'h0, pid: f_pid, sent: 3'b000, fail: 3'b010};
        push_exp(1'b0, e);
        step(3);                                     // c
        f_conn = 1'b0;
        f_eng_rdy = 1'b0;
        f_eng_meta = 32'h0000_BEEF;
        drive_tx(1'b0, 1'b1, 1'b1);
        #1;
        chk("dc_tx_rdy_bypass", 32'(f_if.tx_rdy), 32'h0);
        chk("dc_tx_meta_bypass", f_if.tx_meta, 32'hBEEF);
        chk("dc_eng_acc", 32'(f_eng_acc), 32'h1);
        chk("dc_eng_done", 32'(f_eng_done), 32'h1);
        step(1);                                     // c+1
        f_eng_rdy = 1'b1;
        drive_tx(1'b0, 1'b0, 1'b0);
        f_req = 3'b000;
        #1;
        chk("dc_tx_rdy_follow", 32'(f_if.tx_rdy), 32'h1);
        chk("dc_eng_done_low", 32'(f_eng_done), 32'h0);
        step(1);
        f_conn = 1'b1;
        f_eng_rdy = 1'b0;
        step(1);

        // Reset mid-packet: no pulses, everything back to reset values
        f_req = 3'b001;
        e = '{cyc: 32'(cyc + 1), kind: 1'b0, rdy: 1'b1, meta: 32'h5A, pid: f_pid, sent: 3'b000, fail: 3'b000};
        push_exp(1'b0, e);
        step(2);
        rst = 1'b1;
        f_req = 3'b000;
        step(1);
        rst = 1'b0;
        f_pid = 8'h00;
        r_pid = 8'h00;
        chk("mrst_tx_rdy", 32'(f_if.tx_rdy), 32'h0);
        chk("mrst_busy", 32'(f_busy), 32'h0);
        chk("mrst_sent_fail", 32'({f_sent, f_fail}), 32'h0);
        chk("mrst_pkt_id", 32'(f_if.tx_pkt_id), 32'h0);
        chk("mrst_meta", f_if.tx_meta, 32'h0);
        step(2);

        // Packet ID wrap, acc and done in the same cycle
        f_req = 3'b001;
        for (int i = 0; i < (1 << PW); i++) serve(1'b0, 0, 1, i != (1 << PW) - 1);
        chk("wrap_pkt_id", 32'(f_if.tx_pkt_id), 32'h0);

        // Round-robin: 0,1,2,0 then ptr=1 with req 101 picks 2
        r_req = 3'b111;
        serve(1'b1, 0, 2, 1'b1);
        serve(1'b1, 1, 2, 1'b1);
        serve(1'b1, 2, 2, 1'b1);
        serve(1'b1, 0, 2, 1'b0);
        r_req = 3'b101;
        serve(1'b1, 2, 2, 1'b0);
        r_req = 3'b000;

        step(5);
        chk("fp_queue_drained", 32'(exp_f.size()), 32'h0);
        chk("rr_queue_drained", 32'(exp_r.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
